mod_updown_counter: RTL
=======================

# mod_updown_counter

Parametrised, fully synchronous up/down modulo-N counter: the next generation of the team's 4-bit ripple counter. Adds configurable width and modulus, direction control, parallel load, count enable, a cascade carry chain for building wider counters from several instances, optional Gray-coded output and a sticky wrap flag. All state changes on the rising edge of one clock, with no ripple clocking between bits.

## Interface
- `WIDTH`, 4: counter width in bits, 1..32.
- `MODULUS`, 16: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- `GRAY_OUT`, 0: 1 makes `q_code` Gray-coded; 0 makes `q_code` equal `count`.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset (0 = reset).
- `en` in 1: count enable.
- `cin` in 1: cascade enable from the previous stage; tie to 1 on the first stage.
- `up` in 1: direction, 1 = increment, 0 = decrement.
- `load` in 1: parallel load strobe.
- `load_val` in WIDTH: value to load.
- `clr_wrap` in 1: clears the `wrap` flag.
- `count` out WIDTH: registered binary count.
- `q_code` out WIDTH: registered output code, binary or Gray per `GRAY_OUT`.
- `tc` out 1: terminal count / cascade carry to the next stage (combinational).
- `wrap` out 1: sticky flag, set on any wrap-around.

## Operation
- Priority at each rising `clk` edge: reset, then load, then step, then hold.
- **Reset** (`reset`=0): `count`=0, `q_code`=0, `wrap`=0.
- **Load** (`load`=1):
  - `count` takes `load_val`.
  - If `load_val` ≥ MODULUS, `count` takes MODULUS-1 instead.
  - Load overrides `en` and `cin`; no wrap is flagged.
- **Step** (`en` & `cin` = 1, no load):
  - Up: `count`+1; from MODULUS-1 it goes to 0.
  - Down: `count`-1; from 0 it goes to MODULUS-1.
  - Each of these two transitions sets `wrap`.
- **Hold**: otherwise `count` is unchanged.
- **`tc`** = `en` & `cin` & (`up` ? `count`==MODULUS-1 : `count`==0).
  - Chain stages by driving the next stage's `cin` from this stage's `tc`; `tc` asserts exactly when this stage wraps on the coming edge.
  - `tc` is forced to 0 while `load`=1 or `reset`=0.
- **`wrap`**:
  - `clr_wrap` clears it on the next edge.
  - If a wrap event and `clr_wrap` occur in the same cycle, set wins and `wrap` stays 1.
  - Reset clears it.
- **`q_code`**: when `GRAY_OUT`=1, it is the Gray code of the next `count` value (`n ^ (n>>1)`), registered, so it is cycle-aligned with `count`.
- Arithmetic is WIDTH bits wide. The next-value compare is done before the increment, so `count` never leaves the range 0..MODULUS-1.
- A `up` change takes effect on the next step; there is no dead cycle.
- Illegal `MODULUS` (below 2 or above 2^WIDTH) is a static error at elaboration.

## Timing
- Latency: `count`, `q_code` and `wrap` are registered and reflect the inputs sampled one edge earlier.
- `tc` is combinational from registered `count` plus `en`, `cin`, `up`, `load` and `reset`. It is valid in the same cycle.
- Cascade path: a chain of N stages has N `tc`→`cin` AND-delays per cycle; there is no added latency.
- Reset is synchronous. Asserting it mid-count clears the counter on the next edge, regardless of `load` or `en`. The first step after release happens on the first edge with `reset`=1 and `en`=1.
- Reset output values: `count`=0, `q_code`=0, `wrap`=0. `tc` is 0 while reset is held low.

## Structure
- Shared package `counter_pkg`:
  - function `bin2gray(n)`.
  - elaboration check for `MODULUS` legality.
  - direction constants `CNT_UP`=1, `CNT_DN`=0.
- One sub-module, `mod_step`: combinational next-value and wrap-event logic (inputs `count`, `up`; outputs `next`, `wrap_ev`).
- The top level holds the registers, priority mux, `tc` and the `wrap` flag.

## Test plan
- WIDTH=4, MODULUS=10, `up`=1, `en`=`cin`=1 from reset: `count` runs 0..9 then 0. `tc`=1 only in the cycle where `count`=9. `wrap`=1 from the cycle after.
- Same config, `up`=0 from `count`=0: the next value is 9 and `wrap` is set. Then `clr_wrap` together with another wrap at `count`=0: `wrap` stays 1.
- `load`=1, `load_val`=12 (MODULUS=10): `count`=9. Then `load`=1 and `en`=1 with `load_val`=3: `count`=3 and no wrap.
- Two cascaded instances (MODULUS=10, `tc0`→`cin1`): after 100 enabled clocks from reset, both stages read 0. After 37 clocks, they read 3 (stage 1) and 7 (stage 0).
- GRAY_OUT=1, WIDTH=4, MODULUS=16, counting up: consecutive `q_code` values differ in exactly one bit, including across the 15→0 wrap. `q_code`=4'b1000 when `count`=15.
- `reset`=0 asserted mid-count at `count`=6 with `load`=1 and `en`=1: the next `count`, `q_code` and `wrap` are all 0, and `tc`=0 while reset is low.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the modulo up/down counter family
package counter_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  function automatic logic [31:0] bin2gray(input logic [31:0] n);
    return n ^ (n >> 1);
  endfunction

  // The modulus may equal 2^WIDTH, so the bound is computed in 64 bits.
  function automatic bit modulus_ok(input int width, input longint unsigned modulus);
    return (width >= 1) && (width <= 32) &&
           (modulus >= 64'd2) && (modulus <= (64'd1 << width));
  endfunction

endpackage

// File: rtl/mod_step.sv
// rtl/mod_step.sv - combinational next-value and wrap-event logic for one counter stage
module mod_step
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next,
  output logic             wrap_ev
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  // The terminal compare happens before the add/subtract, so the result never leaves 0..MAX.
  always_comb begin
    next    = count;
    wrap_ev = 1'b0;
    if (up == CNT_UP) begin
      if (count == MAX) begin
        next    = '0;
        wrap_ev = 1'b1;
      end else begin
        next = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        next    = MAX;
        wrap_ev = 1'b1;
      end else begin
        next = count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - synchronous cascadable modulo-N up/down counter with load and sticky wrap
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              GRAY_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cin,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] q_code,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  generate
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("mod_updown_counter: MODULUS must be in 2..2^WIDTH and WIDTH in 1..32");
    end
  endgenerate

  logic [WIDTH-1:0] step_next;
  logic             wrap_ev;
  logic             step;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] next_code;
  logic             wrap_set;

  mod_step #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_step (
    .count  (count),
    .up     (up),
    .next   (step_next),
    .wrap_ev(wrap_ev)
  );

  assign step         = en & cin;
  assign load_clamped = (64'(load_val) >= MODULUS) ? MAX : load_val;
  assign wrap_set     = step & ~load & wrap_ev;

  // Carry to the next stage is exactly "this stage wraps on the coming edge".
  assign tc = reset & wrap_set;

  always_comb begin
    next_count = count;
    if (load) begin
      next_count = load_clamped;
    end else if (step) begin
      next_count = step_next;
    end
  end

  // The code is derived from the next count so it lands in the same register stage as count.
  assign next_code = GRAY_OUT ? WIDTH'(bin2gray(32'(next_count))) : next_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      q_code <= '0;
      wrap   <= 1'b0;
    end else begin
      count  <= next_count;
      q_code <= next_code;
      wrap   <= wrap_set | (wrap & ~clr_wrap);
    end
  end

endmodule
